// File: rtl/motor_cmd_arbiter.sv
// motor_cmd_arbiter
//
// Single owner of the rover's dual H-bridge inputs (IN1..IN4). This block arbitrates
// between four requesters. From highest to lowest priority they are metal-detect stop,
// current-sense stall protection, 180-degree turn requests and navigation steering.
// Every change from brake to a drive pattern, and every change between two different
// drive patterns, passes through a fixed coast (dead-time) window.
//
// Ports:
//   clk1           in   system clock (50 MHz)
//   rst            in   synchronous, active-high reset
//   nav_valid      in   nav_cmd valid this cycle
//   nav_cmd[1:0]   in   00 stop, 01 forward, 10 left, 11 right
//   turn180_req    in   single-cycle 180-degree spin request
//   sense_l/r      in   H-bridge current-sense flags
//   detect         in   inductive sensor hit
//   detect_inhibit in   holds the detect debounce at zero
//   clear_btn      in   operator release button (synchronized, single-cycle)
//   motor_in[3:0]  out  {IN4,IN3,IN2,IN1}, registered
//   state[2:0]     out  current FSM state code
//   busy           out  high in every state except IDLE and DRIVE
//   fault_cnt[3:0] out  stall counter, saturating at 15

module motor_cmd_arbiter #(
    parameter int unsigned DEAD_CYC    = 50_000,
    parameter int unsigned STALL_DEB   = 45_000_000,
    parameter int unsigned BRAKE_CYC   = 50_000_000,
    parameter int unsigned MAX_STALLS  = 3,
    parameter int unsigned DET_DEB     = 1_000_000,
    parameter int unsigned DETECT_HOLD = 250_000_000,
    parameter int unsigned TURN180_CYC = 75_000_000
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       nav_valid,
    input  logic [1:0] nav_cmd,
    input  logic       turn180_req,
    input  logic       sense_l,
    input  logic       sense_r,
    input  logic       detect,
    input  logic       detect_inhibit,
    input  logic       clear_btn,
    output logic [3:0] motor_in,
    output logic [2:0] state,
    output logic       busy,
    output logic [3:0] fault_cnt
);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StDrive      = 3'd1,
        StDead       = 3'd2,
        StSpin180    = 3'd3,
        StBrakeStall = 3'd4,
        StHoldDetect = 3'd5,
        StLatched    = 3'd6
    } st_e;

    localparam logic [3:0] PatFwd   = 4'b1001;
    localparam logic [3:0] PatLeft  = 4'b1010;
    localparam logic [3:0] PatRight = 4'b0101;
    localparam logic [3:0] PatBrake = 4'b1111;
    localparam logic [3:0] PatCoast = 4'b0000;

    // The timed states exit on the edge where the shared timer equals N-1.
    localparam logic [27:0] DEAD_LAST  = 28'(DEAD_CYC - 1);
    localparam logic [27:0] TURN_LAST  = 28'(TURN180_CYC - 1);
    localparam logic [27:0] BRAKE_LAST = 28'(BRAKE_CYC - 1);
    localparam logic [27:0] HOLD_LAST  = 28'(DETECT_HOLD - 1);

    localparam int unsigned SW = (STALL_DEB > 1) ? $clog2(STALL_DEB) : 1;
    localparam int unsigned DW = (DET_DEB > 1) ? $clog2(DET_DEB) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_DEB - 1);
    localparam logic [DW-1:0] DET_LAST   = DW'(DET_DEB - 1);

    function automatic logic [3:0] cmd_pattern(input logic [1:0] cmd);
        logic [3:0] pat;
        unique case (cmd)
            2'b01:   pat = PatFwd;
            2'b10:   pat = PatLeft;
            2'b11:   pat = PatRight;
            default: pat = PatBrake;
        endcase
        return pat;
    endfunction

    st_e         st_q;
    logic [1:0]  cmd_q;        // cmd_reg: last valid navigation command
    logic [1:0]  drive_cmd_q;  // command whose pattern is currently on the bridge in DRIVE
    logic        target_spin_q;
    logic [27:0] timer_q;
    logic [SW-1:0] stall_cnt_q;
    logic [DW-1:0] det_cnt_q;

    logic [1:0] cmd_now;
    logic       sensing;
    logic       detecting;
    logic       stall_evt;
    logic       det_evt;
    logic       det_hit;
    logic       stall_hit;
    logic       turn_hit;
    logic       timed;

    // A command arriving this cycle acts on this edge, which keeps the latency at one cycle.
    assign cmd_now = nav_valid ? nav_cmd : cmd_q;

    assign sensing   = sense_l | sense_r;
    assign detecting = detect & ~detect_inhibit;
    assign stall_evt = sensing && (stall_cnt_q == STALL_LAST);
    assign det_evt   = detecting && (det_cnt_q == DET_LAST);

    assign det_hit   = det_evt && (st_q != StHoldDetect) && (st_q != StLatched);
    // Detect outranks stall, so a simultaneous stall is not counted.
    assign stall_hit = stall_evt && !det_hit &&
                       ((st_q == StDrive) || (st_q == StSpin180) || (st_q == StDead));
    assign turn_hit  = turn180_req && ((st_q == StIdle) || (st_q == StDrive));

    assign timed = (st_q == StDead) || (st_q == StSpin180) ||
                   (st_q == StBrakeStall) || (st_q == StHoldDetect);

    assign state = st_q;

    always_ff @(posedge clk1) begin
        if (rst) begin
            cmd_q <= 2'b00;
        end else if (nav_valid) begin
            cmd_q <= nav_cmd;
        end
    end

    // Debounce counters clear on release and on the event itself, so they never wrap.
    always_ff @(posedge clk1) begin
        if (rst || !sensing || stall_evt) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst || !detecting || det_evt) begin
            det_cnt_q <= '0;
        end else begin
            det_cnt_q <= det_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            st_q          <= StIdle;
            motor_in      <= PatBrake;
            busy          <= 1'b0;
            fault_cnt     <= 4'd0;
            timer_q       <= '0;
            target_spin_q <= 1'b0;
            drive_cmd_q   <= 2'b00;
        end else begin
            // A stall on the same cycle as a clear still counts.
            if (stall_hit) begin
                if (fault_cnt != 4'hF) begin
                    fault_cnt <= fault_cnt + 4'd1;
                end
            end else if (clear_btn) begin
                fault_cnt <= 4'd0;
            end

            // Runs only in timed states. Every state entry below reloads it with zero.
            timer_q <= timed ? timer_q + 28'd1 : '0;

            if (det_hit) begin
                st_q     <= StHoldDetect;
                motor_in <= PatBrake;
                busy     <= 1'b1;
                timer_q  <= '0;
            end else if (stall_hit) begin
                st_q     <= StBrakeStall;
                motor_in <= PatBrake;
                busy     <= 1'b1;
                timer_q  <= '0;
            end else if (turn_hit) begin
                st_q          <= StDead;
                motor_in      <= PatCoast;
                busy          <= 1'b1;
                timer_q       <= '0;
                target_spin_q <= 1'b1;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        if (cmd_now != 2'b00) begin
                            st_q          <= StDead;
                            motor_in      <= PatCoast;
                            busy          <= 1'b1;
                            timer_q       <= '0;
                            target_spin_q <= 1'b0;
                        end
                    end
                    StDrive: begin
                        if (cmd_now == 2'b00) begin
                            st_q     <= StIdle;
                            motor_in <= PatBrake;
                            busy     <= 1'b0;
                            timer_q  <= '0;
                        end else if (cmd_now != drive_cmd_q) begin
                            st_q          <= StDead;
                            motor_in      <= PatCoast;
                            busy          <= 1'b1;
                            timer_q       <= '0;
                            target_spin_q <= 1'b0;
                        end
                    end
                    StDead: begin
                        if (timer_q == DEAD_LAST) begin
                            timer_q <= '0;
                            if (target_spin_q) begin
                                st_q     <= StSpin180;
                                motor_in <= PatRight;
                                busy     <= 1'b1;
                            end else if (cmd_now != 2'b00) begin
                                st_q        <= StDrive;
                                motor_in    <= cmd_pattern(cmd_now);
                                drive_cmd_q <= cmd_now;
                                busy        <= 1'b0;
                            end else begin
                                st_q     <= StIdle;
                                motor_in <= PatBrake;
                                busy     <= 1'b0;
                            end
                        end
                    end
                    StSpin180: begin
                        if (timer_q == TURN_LAST) begin
                            st_q          <= StDead;
                            motor_in      <= PatCoast;
                            busy          <= 1'b1;
                            timer_q       <= '0;
                            target_spin_q <= 1'b0;
                        end
                    end
                    StBrakeStall: begin
                        if (timer_q == BRAKE_LAST) begin
                            timer_q <= '0;
                            busy    <= 1'b1;
                            if (32'(fault_cnt) >= MAX_STALLS) begin
                                st_q     <= StLatched;
                                motor_in <= PatBrake;
                            end else begin
                                st_q          <= StDead;
                                motor_in      <= PatCoast;
                                target_spin_q <= 1'b0;
                            end
                        end
                    end
                    StHoldDetect: begin
                        if (timer_q == HOLD_LAST) begin
                            st_q     <= StLatched;
                            motor_in <= PatBrake;
                            busy     <= 1'b1;
                            timer_q  <= '0;
                        end
                    end
                    StLatched: begin
                        // Release turns the rover away from whatever stopped it.
                        if (clear_btn) begin
                            st_q          <= StDead;
                            motor_in      <= PatCoast;
                            busy          <= 1'b1;
                            timer_q       <= '0;
                            target_spin_q <= 1'b1;
                        end
                    end
                    default: begin
                        st_q     <= StIdle;
                        motor_in <= PatBrake;
                        busy     <= 1'b0;
                        timer_q  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/motor_cmd_arbiter.md
# motor_cmd_arbiter

Arbitrates all requesters of the rover's dual H-bridge (navigation steering, 180° turn requests, current-sense stall protection, metal-detect stop) and produces the four bridge inputs. Sits between the navigation/frequency logic and the H-bridge pins, and is the single owner of IN1–IN4. It enforces the following:
- a fixed priority between requesters;
- dead-time (coast) on every direction reversal;
- a timed brake-and-retry sequence on stall;
- a latched stop that only the operator button releases.

## Interface
- DEAD_CYC, 50_000, coast cycles inserted between two different drive patterns.
- STALL_DEB, 45_000_000, consecutive sense-high cycles that constitute a stall.
- BRAKE_CYC, 50_000_000, brake duration after a stall.
- MAX_STALLS, 3, stall count that forces LATCHED.
- DET_DEB, 1_000_000, consecutive detect-high cycles that constitute a detection.
- DETECT_HOLD, 250_000_000, brake duration after a detection, before LATCHED.
- TURN180_CYC, 75_000_000, right-spin duration for a 180° turn.

Ports (clock and reset first):
- clk1  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- nav_valid  in  1  nav_cmd is valid this cycle.
- nav_cmd  in  2  00 stop, 01 forward, 10 left, 11 right.
- turn180_req  in  1  single-cycle pulse requesting a 180° spin.
- sense_l, sense_r  in  1  H-bridge current-sense flags.
- detect  in  1  inductive sensor hit (OR of both coils).
- detect_inhibit  in  1  when 1, detection debounce is held at 0.
- clear_btn  in  1  operator button, already synchronized and single-cycle.
- motor_in  out  4  {IN4,IN3,IN2,IN1}.
- state  out  3  current FSM state code.
- busy  out  1  high in every state except IDLE and DRIVE.
- fault_cnt  out  4  stall counter, saturating at 15.

## Operation
Output patterns:
- forward = 4'b1001
- left = 4'b1010
- right = 4'b0101
- brake = 4'b1111
- coast = 4'b0000

cmd_reg captures nav_cmd on any cycle where nav_valid=1; the reset value is 00.

Stall debounce:
- stall_cnt increments while (sense_l|sense_r); it clears when both are 0.
- The stall event fires on the cycle stall_cnt reaches STALL_DEB-1; stall_cnt then clears.
- Stall events are only acted on in DRIVE, SPIN180 and DEAD.

Detect debounce works the same way: det_cnt against DET_DEB, cleared while detect_inhibit=1. Detect events are acted on in every state except HOLD_DETECT and LATCHED.

States and codes:
- IDLE (0): motor_in=brake.
  - cmd_reg≠00 → DEAD, with the target set to the cmd pattern.
- DRIVE (1): motor_in=pattern(cmd_reg).
  - cmd_reg=00 → IDLE, immediately.
  - cmd_reg changes to another direction → DEAD.
- DEAD (2): motor_in=coast for DEAD_CYC cycles.
  - Then → SPIN180 if the target is spin.
  - Otherwise → DRIVE if cmd_reg≠00, else IDLE.
- SPIN180 (3): motor_in=right for TURN180_CYC cycles, then → DEAD, targeting cmd_reg.
- BRAKE_STALL (4): motor_in=brake for BRAKE_CYC cycles.
  - → LATCHED if fault_cnt≥MAX_STALLS.
  - Otherwise → DEAD, targeting cmd_reg.
- HOLD_DETECT (5): motor_in=brake for DETECT_HOLD cycles, then → LATCHED.
- LATCHED (6): motor_in=brake.
  - clear_btn → DEAD, target spin (180° turn away).
  - fault_cnt clears at the same time.

Priority, evaluated every cycle: detect > stall > turn180_req > nav.
- Detect event: → HOLD_DETECT.
- Stall event: → BRAKE_STALL, and fault_cnt increments (saturating).
- turn180_req in IDLE/DRIVE: → DEAD, target spin. The request is dropped in any other state; there is no queueing.

clear_btn outside LATCHED clears fault_cnt only.

A single 28-bit timer is shared by all timed states. It is loaded with 0 on every state entry.

## Timing
- All outputs are registered. motor_in and state change on the clock edge after the causing input is sampled, giving 1-cycle latency.
- Entry into brake (BRAKE_STALL, HOLD_DETECT, IDLE) takes effect on that edge with no dead-time.
- Any transition from brake to a drive pattern, or from one drive pattern to a different one, passes through exactly DEAD_CYC cycles of coast.
- Timed states last exactly N cycles of motor_in output: the exit happens on the edge when the timer equals N-1.
- Reset values: motor_in=4'b1111, state=0, busy=0, fault_cnt=0. cmd_reg, the timer, stall_cnt and det_cnt are all 0.
- rst has priority over every input and takes effect mid-sequence from any state.
- A stall or detect event during DEAD preempts the coast immediately.
- A detect event and a stall event in the same cycle: detect wins and fault_cnt is not incremented.
- The counters never wrap: fault_cnt saturates at 15, and stall_cnt/det_cnt clear on an event.

## Test plan
All scenarios use DEAD_CYC=4, STALL_DEB=8, BRAKE_CYC=10, DET_DEB=3, DETECT_HOLD=20, TURN180_CYC=6, MAX_STALLS=3.

- Reset, then nav fwd:
  - motor_in=1111 during rst.
  - After nav_valid with 01: 4 cycles of 0000, then 1001; busy=0.
- Fwd → left: 0000 for exactly 4 cycles, then 1010. Nav 00 then gives 1111 on the next cycle.
- sense_l high 8 cycles in DRIVE: 1111 for 10 cycles, fault_cnt=1, then 0000×4, then 1001.
- Three stalls, then clear_btn:
  - After the third brake: state=6, motor_in held at 1111.
  - clear_btn → 0000×4, then 0101×6, then 0000×4, then the cmd pattern; fault_cnt=0.
- Detect and stall debounces complete on the same cycle: state=5, fault_cnt unchanged; after 20 cycles state=6.
- Mid-sequence inputs:
  - turn180_req during BRAKE_STALL is ignored.
  - rst asserted mid-SPIN180 → motor_in=1111, state=0 on the next edge.
  - detect with detect_inhibit=1 never triggers.
